// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 responder emulating a 25xx160-class EEPROM with an internal byte array.
// Optional build macro SPI_RESP_PAGE_WRAP_EN: WRITE addresses wrap inside a PAGE_BYTES page.
module spi_eeprom_responder #(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned PAGE_BYTES  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic ACLK,
    input  logic RST,
    input  logic SPI_SCK,
    input  logic SPI_CSn,
    input  logic SPI_MOSI,
    output logic SPI_MISO,
    output logic SPI_MISO_OE,
    output logic WEL,
    output logic BUSY
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_ADDR    = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_WR_DATA = 3'd4;
    localparam logic [2:0] ST_RDSR    = 3'd5;
    localparam logic [2:0] ST_IGNORE  = 3'd6;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;

    // Bits of the write address that are allowed to increment.
`ifdef SPI_RESP_PAGE_WRAP_EN
    localparam logic [ADDR_W-1:0] WR_WRAP_MASK = ADDR_W'(PAGE_BYTES - 1);
`else
    localparam logic [ADDR_W-1:0] WR_WRAP_MASK = {ADDR_W{1'b1}} | ADDR_W'(PAGE_BYTES - 1);
`endif

    logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
    logic                   sck_s, csn_s, mosi_s;
    logic                   sck_q, csn_q;
    logic                   active_rise_c, active_fall_c, csn_fall_c;

    logic [2:0]        state, state_nx;
    logic [3:0]        bit_cnt;
    logic [6:0]        shift_in;
    logic [ADDR_W-1:0] addr_sh;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        opcode;
    logic              ign_extra;
    logic              byte_seen;
    logic [2:0]        out_cnt;
    logic [7:0]        miso_sh;

    logic [7:0]        byte_c;
    logic [ADDR_W-1:0] addr_in_c;
    logic [ADDR_W-1:0] wr_next_c;
    logic              rd_en_c, wr_en_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [7:0]        out_src_c;

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data;

    // Pad synchronizers; they carry no state worth resetting.
    always_ff @(posedge ACLK) begin
        sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
        csn_sync  <= {csn_sync[SYNC_STAGES-2:0], SPI_CSn};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // csn_q resets low so a CS held low across reset is not taken as a new frame.
    always_ff @(posedge ACLK) begin
        if (RST) begin
            sck_q <= 1'b0;
            csn_q <= 1'b0;
        end else begin
            sck_q <= sck_s;
            csn_q <= csn_s;
        end
    end

    assign active_rise_c = sck_s & ~sck_q & ~csn_s;
    assign active_fall_c = ~sck_s & sck_q & ~csn_s;
    assign csn_fall_c    = ~csn_s & csn_q;

    assign byte_c    = {shift_in, mosi_s};
    assign addr_in_c = {addr_sh[ADDR_W-2:0], mosi_s};
    assign wr_next_c = (addr & ~WR_WRAP_MASK) | ((addr + ADDR_W'(1)) & WR_WRAP_MASK);

    always_ff @(posedge ACLK) begin
        if (RST) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nx;
            BUSY  <= (state_nx != ST_IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        if (csn_s) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (csn_fall_c) state_nx = ST_CMD;
                ST_CMD: begin
                    if (active_rise_c && bit_cnt == 4'd7) begin
                        case (byte_c)
                            OP_RDSR:           state_nx = ST_RDSR;
                            OP_READ, OP_WRITE: state_nx = ST_ADDR;
                            default:           state_nx = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (active_rise_c && bit_cnt == 4'd15)
                        state_nx = (opcode == OP_READ) ? ST_RD_DATA : ST_WR_DATA;
                end
                default: state_nx = state;
            endcase
        end
    end

    // Serial input path: opcode, address and write-data shifting.
    always_ff @(posedge ACLK) begin
        if (RST) begin
            bit_cnt   <= 4'd0;
            shift_in  <= 7'd0;
            addr_sh   <= '0;
            addr      <= '0;
            opcode    <= 8'd0;
            ign_extra <= 1'b0;
            byte_seen <= 1'b0;
        end else if (csn_fall_c && state == ST_IDLE) begin
            bit_cnt   <= 4'd0;
            shift_in  <= 7'd0;
            ign_extra <= 1'b0;
            byte_seen <= 1'b0;
        end else if (active_rise_c) begin
            case (state)
                ST_CMD: begin
                    shift_in <= byte_c[6:0];
                    if (bit_cnt == 4'd7) begin
                        opcode  <= byte_c;
                        bit_cnt <= 4'd0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_ADDR: begin
                    addr_sh <= addr_in_c;
                    if (bit_cnt == 4'd15) begin
                        bit_cnt <= 4'd0;
                        addr    <= (opcode == OP_READ) ? addr_in_c + ADDR_W'(1) : addr_in_c;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_RD_DATA: begin
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= 4'd0;
                        addr    <= addr + ADDR_W'(1);
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_WR_DATA: begin
                    shift_in <= byte_c[6:0];
                    if (bit_cnt == 4'd7) begin
                        bit_cnt   <= 4'd0;
                        addr      <= wr_next_c;
                        byte_seen <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_IGNORE: ign_extra <= 1'b1;
                default: ;
            endcase
        end
    end

    // Write-enable latch changes only when a frame closes (or on reset).
    always_ff @(posedge ACLK) begin
        if (RST) begin
            WEL <= 1'b0;
        end else if (csn_s && state != ST_IDLE) begin
            if (state == ST_IGNORE && !ign_extra) begin
                if (opcode == OP_WREN)
                    WEL <= 1'b1;
                else if (opcode == OP_WRDI)
                    WEL <= 1'b0;
            end
            if (state == ST_WR_DATA && byte_seen)
                WEL <= 1'b0;
        end
    end

    assign rd_en_c   = active_rise_c &&
                       ((state == ST_ADDR && bit_cnt == 4'd15 && opcode == OP_READ) ||
                        (state == ST_RD_DATA && bit_cnt == 4'd7));
    assign rd_addr_c = (state == ST_ADDR) ? addr_in_c : addr;
    assign wr_en_c   = active_rise_c && state == ST_WR_DATA && bit_cnt == 4'd7 && WEL;

    // Single-port array stored inverted, so a zero-initialised array reads back as erased (FF).
    always_ff @(posedge ACLK) begin
        if (wr_en_c)
            mem[addr] <= ~byte_c;
        else if (rd_en_c)
            rd_data <= ~mem[rd_addr_c];
    end

    assign out_src_c = (state == ST_RDSR) ? {6'b0, WEL, 1'b0} : rd_data;

    // Serial output path: a new byte is loaded on every eighth falling edge.
    always_ff @(posedge ACLK) begin
        if (RST) begin
            SPI_MISO    <= 1'b0;
            SPI_MISO_OE <= 1'b0;
            miso_sh     <= 8'd0;
            out_cnt     <= 3'd0;
        end else begin
            SPI_MISO_OE <= ~csn_s;
            if (csn_s || !(state == ST_RD_DATA || state == ST_RDSR)) begin
                SPI_MISO <= 1'b0;
                out_cnt  <= 3'd0;
            end else if (active_fall_c) begin
                out_cnt <= out_cnt + 3'd1;
                if (out_cnt == 3'd0) begin
                    SPI_MISO <= out_src_c[7];
                    miso_sh  <= {out_src_c[6:0], 1'b0};
                end else begin
                    SPI_MISO <= miso_sh[7];
                    miso_sh  <= {miso_sh[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Directed bench for spi_eeprom_responder acting as a mode-0 SPI master.
module tb_spi_eeprom_responder;

    localparam int HALF = 5;

    logic ACLK = 1'b0;
    logic RST;
    logic SPI_SCK;
    logic SPI_CSn;
    logic SPI_MOSI;
    logic SPI_MISO;
    logic SPI_MISO_OE;
    logic WEL;
    logic BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ACLK = ~ACLK;

    spi_eeprom_responder dut (
        .ACLK        (ACLK),
        .RST         (RST),
        .SPI_SCK     (SPI_SCK),
        .SPI_CSn     (SPI_CSn),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .SPI_MISO_OE (SPI_MISO_OE),
        .WEL         (WEL),
        .BUSY        (BUSY)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            SPI_MOSI = tx[7-i];
            tick(HALF);
            rx[7-i] = SPI_MISO;
            SPI_SCK = 1'b1;
            tick(HALF);
            SPI_SCK = 1'b0;
        end
    endtask

    task automatic cs_begin();
        SPI_CSn = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_end();
        tick(HALF);
        SPI_CSn = 1'b1;
        tick(8);
    endtask

    task automatic send_op(input logic [7:0] op);
        logic [7:0] r;
        cs_begin();
        spi_bits(op, 8, r);
        cs_end();
    endtask

    task automatic do_read(input logic [15:0] a, output logic [7:0] d0, output logic [7:0] d1);
        logic [7:0] r;
        cs_begin();
        spi_bits(8'h03, 8, r);
        spi_bits(a[15:8], 8, r);
        spi_bits(a[7:0], 8, r);
        spi_bits(8'h00, 8, d0);
        spi_bits(8'h00, 8, d1);
        cs_end();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1,
                            input int nbytes, output logic [7:0] rx_or);
        logic [7:0] r;
        cs_begin();
        spi_bits(8'h02, 8, r);
        spi_bits(a[15:8], 8, r);
        spi_bits(a[7:0], 8, r);
        spi_bits(b0, 8, r);
        rx_or = r;
        if (nbytes > 1) begin
            spi_bits(b1, 8, r);
            rx_or = rx_or | r;
        end
        cs_end();
    endtask

    task automatic test_reset();
        RST = 1'b1; SPI_CSn = 1'b1; SPI_SCK = 1'b0; SPI_MOSI = 1'b0;
        tick(6);
        RST = 1'b0;
        tick(2);
        n_tests++; if (SPI_MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", SPI_MISO); end
        n_tests++; if (SPI_MISO_OE !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", SPI_MISO_OE); end
        n_tests++; if (WEL !== 1'b0) begin n_fail++; $display("FAIL reset_wel: got %b expected 0", WEL); end
        n_tests++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    endtask

    task automatic test_wren_rdsr();
        logic [7:0] r;
        send_op(8'h06);
        n_tests++; if (WEL !== 1'b1) begin n_fail++; $display("FAIL t1_wel: got %b expected 1", WEL); end
        cs_begin();
        spi_bits(8'h05, 8, r);
        n_tests++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b expected 1", BUSY); end
        n_tests++; if (SPI_MISO_OE !== 1'b1) begin n_fail++; $display("FAIL t1_oe: got %b expected 1", SPI_MISO_OE); end
        spi_bits(8'h00, 8, r);
        n_tests++; if (r !== 8'h02) begin n_fail++; $display("FAIL t1_rdsr: got %h expected 02", r); end
        cs_end();
        n_tests++; if (SPI_MISO_OE !== 1'b0) begin n_fail++; $display("FAIL t1_oe_off: got %b expected 0", SPI_MISO_OE); end
        n_tests++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL t1_idle: got %b expected 0", BUSY); end
    endtask

    task automatic test_write_read();
        logic [7:0] rx, d0, d1;
        send_op(8'h06);
        do_write(16'h00F0, 8'hAA, 8'hAB, 2, rx);
        n_tests++; if (rx !== 8'h00) begin n_fail++; $display("FAIL t2_miso_during_write: got %h expected 00", rx); end
        n_tests++; if (WEL !== 1'b0) begin n_fail++; $display("FAIL t2_wel_cleared: got %b expected 0", WEL); end
        do_read(16'h00F0, d0, d1);
        n_tests++; if (d0 !== 8'hAA) begin n_fail++; $display("FAIL t2_rd0: got %h expected AA", d0); end
        n_tests++; if (d1 !== 8'hAB) begin n_fail++; $display("FAIL t2_rd1: got %h expected AB", d1); end
    endtask

    task automatic test_write_protect();
        logic [7:0] rx, d0, d1;
        do_write(16'h0010, 8'h55, 8'h00, 1, rx);
        do_read(16'h0010, d0, d1);
        n_tests++; if (d0 !== 8'hFF) begin n_fail++; $display("FAIL t3_protected: got %h expected FF", d0); end
    endtask

    task automatic test_page_wrap();
        logic [7:0] rx, d0, d1, e000, e010;
`ifdef SPI_RESP_PAGE_WRAP_EN
        e000 = 8'h22; e010 = 8'hFF;
`else
        e000 = 8'hFF; e010 = 8'h22;
`endif
        send_op(8'h06);
        do_write(16'h000F, 8'h11, 8'h22, 2, rx);
        do_read(16'h000F, d0, d1);
        n_tests++; if (d0 !== 8'h11) begin n_fail++; $display("FAIL t4_00f: got %h expected 11", d0); end
        do_read(16'h0000, d0, d1);
        n_tests++; if (d0 !== e000) begin n_fail++; $display("FAIL t4_000: got %h expected %h", d0, e000); end
        do_read(16'h0010, d0, d1);
        n_tests++; if (d0 !== e010) begin n_fail++; $display("FAIL t4_010: got %h expected %h", d0, e010); end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] d0, d1, e000;
`ifdef SPI_RESP_PAGE_WRAP_EN
        e000 = 8'h22;
`else
        e000 = 8'hFF;
`endif
        do_read(16'h07FF, d0, d1);
        n_tests++; if (d0 !== 8'hFF) begin n_fail++; $display("FAIL t5_7ff: got %h expected FF", d0); end
        n_tests++; if (d1 !== e000) begin n_fail++; $display("FAIL t5_wrap_000: got %h expected %h", d1, e000); end
        do_read(16'hF80F, d0, d1);
        n_tests++; if (d0 !== 8'h11) begin n_fail++; $display("FAIL t5_upper_ignored: got %h expected 11", d0); end
    endtask

    task automatic test_wel_rules();
        logic [7:0] r, rx, d0, d1;
        send_op(8'h06);
        send_op(8'h04);
        n_tests++; if (WEL !== 1'b0) begin n_fail++; $display("FAIL wrdi: got %b expected 0", WEL); end
        cs_begin();
        spi_bits(8'h06, 8, r);
        spi_bits(8'h00, 8, r);
        cs_end();
        n_tests++; if (WEL !== 1'b0) begin n_fail++; $display("FAIL wren_16bits: got %b expected 0", WEL); end
        send_op(8'h06);
        cs_begin();
        spi_bits(8'h04, 4, r);
        cs_end();
        n_tests++; if (WEL !== 1'b1) begin n_fail++; $display("FAIL wrdi_partial: got %b expected 1", WEL); end
        cs_begin();
        spi_bits(8'h02, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h30, 8, r);
        spi_bits(8'h5A, 4, r);
        cs_end();
        n_tests++; if (WEL !== 1'b1) begin n_fail++; $display("FAIL write_partial_wel: got %b expected 1", WEL); end
        send_op(8'h04);
        do_read(16'h0030, d0, d1);
        n_tests++; if (d0 !== 8'hFF) begin n_fail++; $display("FAIL write_partial_data: got %h expected FF", d0); end
        rx = 8'h00;
    endtask

    task automatic test_reset_mid();
        logic [7:0] r, d0, d1;
        send_op(8'h06);
        cs_begin();
        spi_bits(8'h02, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h20, 8, r);
        spi_bits(8'h5A, 4, r);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(1);
        n_tests++; if (WEL !== 1'b0) begin n_fail++; $display("FAIL t6_wel: got %b expected 0", WEL); end
        n_tests++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL t6_busy: got %b expected 0", BUSY); end
        SPI_CSn = 1'b1;
        tick(8);
        cs_begin();
        spi_bits(8'h05, 8, r);
        spi_bits(8'h00, 8, r);
        cs_end();
        n_tests++; if (r !== 8'h00) begin n_fail++; $display("FAIL t6_rdsr: got %h expected 00", r); end
        do_read(16'h0020, d0, d1);
        n_tests++; if (d0 !== 8'hFF) begin n_fail++; $display("FAIL t6_not_written: got %h expected FF", d0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        logic [7:0] exp_rd [4];
        exp_rd[0] = 8'hAA; exp_rd[1] = 8'hAB; exp_rd[2] = 8'hFF; exp_rd[3] = 8'hFF;
        send_op(8'h06);
        cs_begin();
        spi_bits(8'h05, 8, r);
        for (int i = 0; i < 3; i++) begin
            spi_bits(8'h00, 8, r);
            n_tests++; if (r !== 8'h02) begin n_fail++; $display("FAIL b2b_rdsr[%0d]: got %h expected 02", i, r); end
        end
        cs_end();
        cs_begin();
        spi_bits(8'h03, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'hF0, 8, r);
        for (int i = 0; i < 4; i++) begin
            spi_bits(8'h00, 8, r);
            n_tests++; if (r !== exp_rd[i]) begin n_fail++; $display("FAIL b2b_read[%0d]: got %h expected %h", i, r, exp_rd[i]); end
        end
        cs_end();
        send_op(8'h04);
    endtask

    initial begin
        test_reset();
        test_wren_rdsr();
        test_write_read();
        test_write_protect();
        test_page_wrap();
        test_addr_wrap();
        test_wel_rules();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
